// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory and decode.
// The master modport is the fetch stage; the slave modport is its environment.
interface fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [PC_W-1:0]    out_pc_next;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output out_valid, out_instr, out_pc, out_pc_next,
    input  out_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  out_valid, out_instr, out_pc, out_pc_next,
    output out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight and
// buffers returned instructions for decode, with redirect/flush and sticky halt.
module fetch_unit #(
  parameter int              PC_W       = 16,
  parameter int              INSTR_W    = 16,
  parameter int              PC_INC     = 2,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC   = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            halt_in,
  output logic            halted,
  fetch_unit_if.master    bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    pc_nxt_s;
  logic [PC_W-1:0]    req_pc_r;
  logic [PC_W-1:0]    req_pc_nxt_s;
  logic [CNT_W-1:0]   count_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [INSTR_W-1:0] instr_mem_r [FIFO_DEPTH];
  logic [PC_W-1:0]    pc_mem_r    [FIFO_DEPTH];

  logic req_s;
  logic gnt_s;
  logic push_s;
  logic pop_s;
  logic flush_s;
  logic out_valid_s;

  // Request, handshake qualifiers and head-of-FIFO outputs
  always_comb begin
    req_s       = rst && (state_r == ST_REQ) && (count_r < CNT_W'(FIFO_DEPTH));
    gnt_s       = req_s && bus.imem_gnt;
    out_valid_s = rst && (state_r != ST_HALT) && (count_r != {CNT_W{1'b0}});
    pop_s       = out_valid_s && bus.out_ready && !flush_s;

    bus.imem_req    = req_s;
    bus.imem_addr   = pc_r;
    bus.out_valid   = out_valid_s;
    bus.out_instr   = instr_mem_r[rd_ptr_r];
    bus.out_pc      = pc_mem_r[rd_ptr_r];
    bus.out_pc_next = pc_mem_r[rd_ptr_r] + PC_W'(PC_INC);
    halted          = (state_r == ST_HALT);
  end

  // Next-state, PC update, push and flush decisions
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    req_pc_nxt_s = req_pc_r;
    push_s       = 1'b0;
    flush_s      = 1'b0;

    case (state_r)
      ST_REQ: begin
        if (gnt_s) begin
          req_pc_nxt_s = pc_r;
          pc_nxt_s     = pc_r + PC_W'(PC_INC);
          state_nxt_s  = ST_WAIT;
        end else begin
          state_nxt_s  = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          push_s      = 1'b1;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (bus.imem_rvalid) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_REQ;
      end
    endcase

    // Halt beats redirect; both flush and neither lets a response into the FIFO
    if (state_r != ST_HALT) begin
      if (halt_in) begin
        flush_s     = 1'b1;
        push_s      = 1'b0;
        state_nxt_s = ST_HALT;
      end else if (redirect_valid) begin
        flush_s  = 1'b1;
        push_s   = 1'b0;
        pc_nxt_s = redirect_pc;
        case (state_r)
          ST_REQ:  state_nxt_s = gnt_s ? ST_DROP : ST_REQ;
          ST_WAIT: state_nxt_s = bus.imem_rvalid ? ST_REQ : ST_DROP;
          // A response arriving here retires the orphaned request already
          ST_DROP: state_nxt_s = bus.imem_rvalid ? ST_REQ : ST_DROP;
          default: state_nxt_s = ST_REQ;
        endcase
      end else begin
        flush_s = 1'b0;
      end
    end else begin
      flush_s = 1'b0;
    end
  end

  // Control state, PC and FIFO bookkeeping
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_REQ;
      pc_r     <= RESET_PC;
      req_pc_r <= RESET_PC;
      count_r  <= {CNT_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      req_pc_r <= req_pc_nxt_s;
      if (flush_s) begin
        count_r  <= {CNT_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
      end else begin
        count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end else begin
          rd_ptr_r <= rd_ptr_r;
        end
      end
    end
  end

  // FIFO payload storage; contents are only meaningful below count_r
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      instr_mem_r[wr_ptr_r] <= bus.imem_rdata;
      pc_mem_r[wr_ptr_r]    <= req_pc_r;
    end
  end

endmodule
